systolic_seq_ctrl: RTL
======================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for one matrix-multiply pass on the ARRAY_DIM x ARRAY_DIM output-stationary MAC array.
//  Runs the pass in order: clears the array accumulators, streams k_len operand addresses to the A/B
//  operand buffers, and generates diagonally skewed lane valids for the array edge. It then waits
//  for the array to flush and drains the result rows to a sink under a ready handshake.
//  Sits between the host/command logic (start/done) and the array plus its operand and result buffers.
// PARAMETERS
//  ARRAY_DIM   4   array rows = array columns = skew lanes
//  K_WIDTH     8   width of k_len (inner dimension)
//  ADDR_WIDTH  8   operand buffer address width; must be >= K_WIDTH
// PORTS
//  clk          in   1                   single clock, all logic on posedge
//  rst          in   1                   synchronous, active-high reset
//  start        in   1                   pass request; sampled only in IDLE
//  k_len        in   K_WIDTH             inner dimension; latched on accepted start
//  drain_ready  in   1                   result sink can accept the current row
//  busy         out  1                   high in every state except IDLE
//  done         out  1                   one-cycle pulse at pass end
//  acc_clr      out  1                   one-cycle accumulator clear to the array
//  buf_rd_en    out  1                   operand buffer read strobe
//  buf_rd_addr  out  ADDR_WIDTH          operand buffer address (k index)
//  lane_valid   out  ARRAY_DIM           skewed operand-valid, bit i = array row/col lane i
//  drain_en     out  1                   result row presented to the sink
//  drain_row    out  $clog2(ARRAY_DIM)   index of the row being drained
// BEHAVIOUR
//  Reset (synchronous, any state, including mid-pass):
//   - State = IDLE; all outputs 0; lane_valid shift register cleared.
//   - Latched k_len and all counters cleared. No done pulse is produced for the aborted pass.
//  States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
//   - IDLE:
//     - start=1 and k_len!=0: latch k_len, go to CLEAR.
//     - start=1 and k_len==0: ignored, stay IDLE, no busy, no done.
//   - CLEAR: exactly 1 cycle with acc_clr=1, then FEED.
//   - FEED: buf_rd_en=1 every cycle; buf_rd_addr = 0,1,...,k_len-1, one per cycle, zero-extended.
//     After addr k_len-1 go to FLUSH. buf_rd_addr returns to 0 outside FEED.
//   - FLUSH: 2*ARRAY_DIM-1 cycles (counter); covers skew plus array propagation. Then DRAIN.
//   - DRAIN: drain_en=1, drain_row starts at 0.
//     - A row transfers when drain_en && drain_ready; drain_row increments on each transfer.
//     - drain_row holds while drain_ready=0; there is no timeout.
//     - Transfer of row ARRAY_DIM-1 goes to DONE; drain_row wraps to 0.
//   - DONE: done=1 for 1 cycle, then IDLE. busy drops in the cycle after done.
//  start while busy=1 is ignored; it is not queued.
//  Lane skew (operand buffer read latency is 1 cycle):
//   - lane_valid[0] = buf_rd_en delayed 1 cycle.
//   - lane_valid[i] = lane_valid[0] delayed i cycles.
//   - Registered shift chain; it keeps shifting in FLUSH so the tail drains to all-zero.
//  Timing from start accepted at cycle 0:
//   - acc_clr at cycle 1.
//   - FEED spans cycles 2..k_len+1.
//   - FLUSH ends at cycle k_len+2*ARRAY_DIM.
//   - DRAIN spans >= ARRAY_DIM cycles.
//   - With drain_ready held at 1, done is at cycle k_len+3*ARRAY_DIM+1.
//  k_len = 2^K_WIDTH-1 is legal; counters must not wrap early.
//  Outputs acc_clr, buf_rd_en, drain_en and done are mutually exclusive in any cycle.
// TESTING
//  1. N=4, start with k_len=3, drain_ready=1:
//     acc_clr@1; rd_en@2..4, addr 0,1,2; lane_valid[0]@3..5, [3]@6..8;
//     drain_en@12..15, rows 0..3; done@16; busy 1..16.
//  2. start with k_len=0 -> no state change; busy, acc_clr, done stay 0.
//  3. Drain backpressure, k_len=1: drain_ready=0 for 5 cycles at row 2 ->
//     drain_row holds at 2, drain_en stays 1; done 5 cycles later than with ready=1.
//  4. start pulses in FEED and DRAIN -> ignored; exactly one done; addr sequence unchanged.
//  5. rst asserted during FEED at addr 5 (k_len=10) -> next cycle all outputs 0, IDLE, no done;
//     a new start runs a clean pass from addr 0.
//  6. k_len=255 (K_WIDTH=8) -> 255 reads, addr 0..254, last addr 254, done at cycle 268 (N=4).

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for an output-stationary MAC array:
// clear, operand feed with skewed lane valids, flush, row drain.
module systolic_seq_ctrl #(
    parameter int ARRAY_DIM  = 4,
    parameter int K_WIDTH    = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         drain_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         acc_clr,
    output logic                         buf_rd_en,
    output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
    output logic [ARRAY_DIM-1:0]         lane_valid,
    output logic                         drain_en,
    output logic [$clog2(ARRAY_DIM)-1:0] drain_row
);

    localparam int ROW_W     = $clog2(ARRAY_DIM);
    localparam int FLUSH_CYC = 2 * ARRAY_DIM - 1;
    localparam int FL_W      = $clog2(FLUSH_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [K_WIDTH-1:0]   k_len_q, k_len_d;
    logic [K_WIDTH-1:0]   k_cnt_q, k_cnt_d;
    logic [FL_W-1:0]      fl_cnt_q, fl_cnt_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ARRAY_DIM-1:0] lane_q, lane_d;

    // Strobes are pure decodes of the state register, so they are
    // mutually exclusive by construction.
    assign busy        = (state_q != S_IDLE);
    assign acc_clr     = (state_q == S_CLEAR);
    assign buf_rd_en   = (state_q == S_FEED);
    assign drain_en    = (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign buf_rd_addr = buf_rd_en ? ADDR_WIDTH'(k_cnt_q) : '0;
    assign drain_row   = row_q;
    assign lane_valid  = lane_q;

    // Next-state, counters and the lane skew chain.
    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        k_cnt_d  = k_cnt_q;
        fl_cnt_d = fl_cnt_q;
        row_d    = row_q;
        // Chain keeps shifting in every state so the tail empties.
        lane_d   = {lane_q[ARRAY_DIM-2:0], buf_rd_en};

        unique case (state_q)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    k_len_d = k_len;
                    k_cnt_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                // Compare against k_len-1 so k_len = max never wraps.
                if (k_cnt_q == k_len_q - K_WIDTH'(1)) begin
                    k_cnt_d  = '0;
                    fl_cnt_d = '0;
                    state_d  = S_FLUSH;
                end else begin
                    k_cnt_d = k_cnt_q + K_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                if (fl_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
                    fl_cnt_d = '0;
                    row_d    = '0;
                    state_d  = S_DRAIN;
                end else begin
                    fl_cnt_d = fl_cnt_q + FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_ready) begin
                    if (row_q == ROW_W'(ARRAY_DIM - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_len_q  <= '0;
            k_cnt_q  <= '0;
            fl_cnt_q <= '0;
            row_q    <= '0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_len_q  <= k_len_d;
            k_cnt_q  <= k_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            row_q    <= row_d;
            lane_q   <= lane_d;
        end
    end

endmodule
